// File: rtl/mem_interface_if.sv
// Request/acknowledge memory bus between the memory-side stage (master) and the memory slave.
interface mem_interface_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_interface.sv
// Converts multicycle-control memory strobes into one req/ack bus transaction,
// latches read data into IR/MDR and stalls control until the access completes.
module mem_interface #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  input  logic              ior_d,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] write_data,
  mem_interface_if.master   bus,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              bus_err
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             fetch, load;
  logic             pending, timeout_hit;

  assign pending     = mem_read | mem_write | ir_write;
  // cnt holds the number of REQ cycles already spent without ack
  assign timeout_hit = (state == REQ) && !bus.bus_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Gated by reset so stall is low while reset is held, even with strobes active
  always_comb begin
    stall = 1'b0;
    if (rst_n)
      stall = ((state == IDLE) && pending) ||
              ((state == REQ) && !bus.bus_ack && !timeout_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      fetch         <= 1'b0;
      load          <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      instr         <= '0;
      mdr           <= '0;
      bus_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            bus.bus_addr  <= ior_d ? alu_out : pc;
            bus.bus_we    <= mem_write;
            bus.bus_wdata <= write_data;
            // A store wins over any simultaneous read/fetch strobe
            fetch         <= ir_write & ~mem_write;
            load          <= mem_read & ~mem_write;
            cnt           <= '0;
            bus.bus_req   <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            if (fetch) instr <= bus.bus_rdata;
            if (load)  mdr   <= bus.bus_rdata;
            bus.bus_req <= 1'b0;
            state       <= IDLE;
          end else if (timeout_hit) begin
            bus_err     <= 1'b1;
            bus.bus_req <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_interface.sv
// Directed self-checking bench for mem_interface: fetch, load, store, timeout, async reset, back-to-back.
module tb_mem_interface;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read = 1'b0, mem_write = 1'b0, ir_write = 1'b0, ior_d = 1'b0;
  logic [AW-1:0] pc = '0, alu_out = '0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] instr, mdr;
  logic          stall, bus_err;

  int errors = 0;
  int checks = 0;

  mem_interface_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_interface #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .ior_d      (ior_d),
    .pc         (pc),
    .alu_out    (alu_out),
    .write_data (write_data),
    .bus        (bus.master),
    .instr      (instr),
    .mdr        (mdr),
    .stall      (stall),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;

    // Reset state
    #12;
    chk("rst_req",   32'(bus.bus_req), 32'd0);
    chk("rst_we",    32'(bus.bus_we),  32'd0);
    chk("rst_stall", 32'(stall),       32'd0);
    chk("rst_err",   32'(bus_err),     32'd0);
    chk("rst_addr",  bus.bus_addr,     32'd0);
    chk("rst_instr", instr,            32'd0);
    chk("rst_mdr",   mdr,              32'd0);
    rst_n = 1'b1;

    // T1: fetch from pc, ack in first REQ cycle
    nxt(); ir_write = 1'b1; pc = 32'h40; ior_d = 1'b0;
    smp(); chk("t1_stall_idle", 32'(stall), 32'd1); chk("t1_req_idle", 32'(bus.bus_req), 32'd0);
    nxt(); bus.bus_ack = 1'b1; bus.bus_rdata = 32'h8C22_0004;
    smp(); chk("t1_req", 32'(bus.bus_req), 32'd1); chk("t1_addr", bus.bus_addr, 32'h40);
    chk("t1_we", 32'(bus.bus_we), 32'd0); chk("t1_stall_ack", 32'(stall), 32'd0);
    nxt(); bus.bus_ack = 1'b0; ir_write = 1'b0;
    smp(); chk("t1_req_done", 32'(bus.bus_req), 32'd0); chk("t1_instr", instr, 32'h8C22_0004);
    chk("t1_mdr", mdr, 32'd0);

    // T2: load from alu_out with 3 wait cycles
    nxt(); mem_read = 1'b1; ior_d = 1'b1; alu_out = 32'h100;
    smp(); chk("t2_stall_idle", 32'(stall), 32'd1);
    nxt(); smp(); chk("t2_req", 32'(bus.bus_req), 32'd1); chk("t2_addr", bus.bus_addr, 32'h100);
    chk("t2_stall_w1", 32'(stall), 32'd1);
    nxt(); smp(); chk("t2_stall_w2", 32'(stall), 32'd1);
    nxt(); smp(); chk("t2_stall_w3", 32'(stall), 32'd1);
    nxt(); bus.bus_ack = 1'b1; bus.bus_rdata = 32'hDEAD_BEEF;
    smp(); chk("t2_stall_ack", 32'(stall), 32'd0);
    nxt(); bus.bus_ack = 1'b0; mem_read = 1'b0;
    smp(); chk("t2_mdr", mdr, 32'hDEAD_BEEF); chk("t2_instr", instr, 32'h8C22_0004);
    chk("t2_req_done", 32'(bus.bus_req), 32'd0);

    // T3: store (with a simultaneous read strobe that must be ignored); data frozen while in REQ
    nxt(); mem_write = 1'b1; mem_read = 1'b1; alu_out = 32'h104; write_data = 32'h1234;
    smp(); chk("t3_stall_idle", 32'(stall), 32'd1);
    nxt(); smp(); chk("t3_we", 32'(bus.bus_we), 32'd1); chk("t3_wdata", bus.bus_wdata, 32'h1234);
    chk("t3_addr", bus.bus_addr, 32'h104);
    nxt(); write_data = 32'hFFFF; alu_out = 32'h999;
    smp(); chk("t3_wdata_frz", bus.bus_wdata, 32'h1234); chk("t3_addr_frz", bus.bus_addr, 32'h104);
    nxt(); bus.bus_ack = 1'b1; bus.bus_rdata = 32'hAAAA_5555;
    smp(); chk("t3_stall_ack", 32'(stall), 32'd0); chk("t3_we_ack", 32'(bus.bus_we), 32'd1);
    nxt(); bus.bus_ack = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    smp(); chk("t3_mdr", mdr, 32'hDEAD_BEEF); chk("t3_instr", instr, 32'h8C22_0004);
    chk("t3_req_done", 32'(bus.bus_req), 32'd0); chk("t3_err", 32'(bus_err), 32'd0);

    // T4: no ack; abort after TO request cycles, sticky error, next fetch still works
    nxt(); ir_write = 1'b1; ior_d = 1'b0; pc = 32'h80;
    smp(); chk("t4_stall_idle", 32'(stall), 32'd1);
    for (int i = 1; i <= TO; i++) begin
      nxt(); smp();
      chk($sformatf("t4_req_c%0d", i), 32'(bus.bus_req), 32'd1);
      chk($sformatf("t4_stall_c%0d", i), 32'(stall), (i < TO) ? 32'd1 : 32'd0);
    end
    nxt(); ir_write = 1'b0;
    smp(); chk("t4_req_drop", 32'(bus.bus_req), 32'd0); chk("t4_err", 32'(bus_err), 32'd1);
    chk("t4_instr", instr, 32'h8C22_0004); chk("t4_stall", 32'(stall), 32'd0);
    nxt(); ir_write = 1'b1; pc = 32'h44;
    smp(); chk("t4b_stall_idle", 32'(stall), 32'd1);
    nxt(); bus.bus_ack = 1'b1; bus.bus_rdata = 32'h0123_4567;
    smp(); chk("t4b_addr", bus.bus_addr, 32'h44); chk("t4b_stall_ack", 32'(stall), 32'd0);
    nxt(); bus.bus_ack = 1'b0; ir_write = 1'b0;
    smp(); chk("t4b_instr", instr, 32'h0123_4567); chk("t4b_err", 32'(bus_err), 32'd1);

    // T5: asynchronous reset in the middle of a REQ
    nxt(); mem_read = 1'b1; ior_d = 1'b1; alu_out = 32'h200;
    smp();
    nxt(); smp(); chk("t5_req_pre", 32'(bus.bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_req",   32'(bus.bus_req), 32'd0);
    chk("t5_stall", 32'(stall),       32'd0);
    chk("t5_instr", instr,            32'd0);
    chk("t5_mdr",   mdr,              32'd0);
    chk("t5_err",   32'(bus_err),     32'd0);
    mem_read = 1'b0;
    #1 rst_n = 1'b1;
    nxt(); smp(); chk("t5_req_post", 32'(bus.bus_req), 32'd0); chk("t5_stall_post", 32'(stall), 32'd0);
    nxt(); ir_write = 1'b1; ior_d = 1'b0; pc = 32'h10;
    smp(); chk("t5_idle_stall", 32'(stall), 32'd1); chk("t5_idle_req", 32'(bus.bus_req), 32'd0);
    nxt(); bus.bus_ack = 1'b1; bus.bus_rdata = 32'hCAFE_F00D;
    smp(); chk("t5_fetch_addr", bus.bus_addr, 32'h10);
    nxt(); bus.bus_ack = 1'b0; ir_write = 1'b0;
    smp(); chk("t5_fetch_instr", instr, 32'hCAFE_F00D);

    // T6: store acked, fetch requested on the very next cycle
    nxt(); mem_write = 1'b1; ior_d = 1'b1; alu_out = 32'h300; write_data = 32'h77;
    smp();
    nxt(); bus.bus_ack = 1'b1;
    smp(); chk("t6_req1", 32'(bus.bus_req), 32'd1); chk("t6_we1", 32'(bus.bus_we), 32'd1);
    chk("t6_stall_ack", 32'(stall), 32'd0);
    nxt(); bus.bus_ack = 1'b0; mem_write = 1'b0; ir_write = 1'b1; ior_d = 1'b0; pc = 32'h48;
    smp(); chk("t6_gap_req", 32'(bus.bus_req), 32'd0); chk("t6_gap_stall", 32'(stall), 32'd1);
    nxt(); smp(); chk("t6_req2", 32'(bus.bus_req), 32'd1); chk("t6_addr2", bus.bus_addr, 32'h48);
    chk("t6_we2", 32'(bus.bus_we), 32'd0);
    nxt(); bus.bus_ack = 1'b1; bus.bus_rdata = 32'h1111_2222;
    smp();
    nxt(); bus.bus_ack = 1'b0; ir_write = 1'b0;
    smp(); chk("t6_instr", instr, 32'h1111_2222); chk("t6_mdr", mdr, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
